// File: rtl/gpio_cmd_pkg.sv
// Shared constants for the GPIO command bridge: command bit positions in the
// micro's output word, status bit positions in the word read back, the payload
// offset and the control FSM state encoding.
package gpio_cmd_pkg;

  // Command bits in i_gpio_o
  localparam int CMD_SOFT_RST = 0;
  localparam int CMD_START    = 1;
  localparam int CMD_READ     = 2;
  localparam int CMD_WRITE    = 3;

  // Status bits in o_gpio_i
  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_FULL  = 3;
  localparam int ST_ERR   = 4;

  // Write payload and FIFO head both live from this bit upward
  localparam int PAYLOAD_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/gpio_cmd_bridge_res_fifo.sv
// Synchronous first-word-fall-through FIFO for convolution results.
// Latency: a pushed word is visible on head the cycle after the push; flags are registered.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; flush wins.
// Ports: clk/rst (sync, active-high), push/wdata, pop, flush, empty, full, head
// (head reads zero while empty).
module res_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  input  logic         flush,
  output logic         empty,
  output logic         full,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_pop, do_push;

  // A pop in the same cycle makes room, so a full FIFO still accepts the push.
  assign do_pop  = pop & ~empty_q & ~flush;
  assign do_push = push & ~flush & (~full_q | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);

    // Head is registered: if the next head slot is the one being written this
    // cycle, forward the incoming word instead of the stale memory entry.
    head_d = '0;
    if (!empty_d) begin
      if (do_push && (rd_ptr_d == wr_ptr_q)) head_d = wdata;
      else                                   head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      head_q   <= head_d;
    end
  end

  assign empty = empty_q;
  assign full  = full_q;
  assign head  = head_q;

endmodule

// File: rtl/gpio_cmd_bridge.sv
// Bridges MicroBlaze GPIO words to datapath pulses/write beats and reads results back.
// Latency: a command bit rising at the GPIO input gives its pulse two clocks later; status updates with it.
// Backpressure: results are held off with o_res_ready while the FIFO is full (unless popping) or flushing.
// Ports: CLK100MHZ, i_rst (sync, active-high); i_gpio_o command word in, o_gpio_i status word out;
// o_soft_rst/o_start/o_wr_valid+o_wr_data to the datapath; i_res_valid/i_res_data/o_res_ready
// result stream; i_done end-of-frame; o_led done indicator.
module gpio_cmd_bridge #(
  parameter int GPIO_D     = 32,
  parameter int NB_WDATA   = 24,
  parameter int NB_RES     = 13,  // must not exceed NB_WDATA / the 24 upper status bits
  parameter int FIFO_DEPTH = 8
) (
  input  logic                CLK100MHZ,
  input  logic                i_rst,
  input  logic [GPIO_D-1:0]   i_gpio_o,
  output logic [GPIO_D-1:0]   o_gpio_i,
  output logic                o_soft_rst,
  output logic                o_start,
  output logic                o_wr_valid,
  output logic [NB_WDATA-1:0] o_wr_data,
  input  logic                i_res_valid,
  input  logic [NB_RES-1:0]   i_res_data,
  output logic                o_res_ready,
  input  logic                i_done,
  output logic                o_led
);

  import gpio_cmd_pkg::*;

  // Input word register; no reset so a command held high through reset is
  // seen as a rise against the cleared prev register on the first free cycle.
  logic [GPIO_D-1:0] gpio_q, gpio_d;
  logic [3:0]        prev_q, prev_d;
  logic [3:0]        rise;

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                start_pend_q, start_pend_d;
  logic                soft_rst_q, soft_rst_d;
  logic                start_q, start_d;
  logic                wr_valid_q, wr_valid_d;
  logic [NB_WDATA-1:0] wr_data_q, wr_data_d;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_empty, fifo_full;
  logic [NB_RES-1:0] fifo_head;
  logic              run_now;
  logic              unused_rsvd;

  assign gpio_d      = i_gpio_o;
  assign prev_d      = gpio_q[3:0];
  assign rise        = gpio_q[3:0] & ~prev_q;
  assign unused_rsvd = ^gpio_q[7:4];

  // A deferred start executes this cycle, so command bits are judged as in RUN.
  assign run_now = start_pend_q | (state_q == S_RUN);

  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    err_d        = err_q;
    start_pend_d = 1'b0;
    soft_rst_d   = 1'b0;
    start_d      = 1'b0;
    wr_valid_d   = 1'b0;
    wr_data_d    = wr_data_q;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;

    if (rise[CMD_SOFT_RST]) begin
      // Soft reset swallows every other command rising alongside it.
      soft_rst_d = 1'b1;
      fifo_flush = 1'b1;
      err_d      = 1'b0;
      done_d     = 1'b0;
      state_d    = S_IDLE;
    end else begin
      if (rise[CMD_READ]) begin
        if (fifo_empty) err_d    = 1'b1;
        else            fifo_pop = 1'b1;
      end

      if (start_pend_q) begin
        start_d = 1'b1;
        state_d = S_RUN;
        done_d  = 1'b0;
      end

      if (run_now) begin
        if (rise[CMD_WRITE] | rise[CMD_START]) err_d = 1'b1;
      end else if (rise[CMD_WRITE]) begin
        wr_valid_d   = 1'b1;
        wr_data_d    = gpio_q[PAYLOAD_LSB +: NB_WDATA];
        state_d      = S_LOAD;
        done_d       = 1'b0;
        // Write goes out first; a simultaneous start follows one cycle later.
        start_pend_d = rise[CMD_START];
      end else if (rise[CMD_START]) begin
        start_d = 1'b1;
        state_d = S_RUN;
        done_d  = 1'b0;
      end

      if ((state_q == S_RUN) && i_done) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end

    busy_d = (state_d == S_RUN);
  end

  // Ready is raised by a same-cycle pop so a full FIFO can swap a word; a
  // flush cycle refuses data rather than accept and discard it.
  assign o_res_ready = ~fifo_flush & (~fifo_full | fifo_pop);
  assign fifo_push   = i_res_valid & o_res_ready;

  res_fifo #(
    .W     (NB_RES),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk   (CLK100MHZ),
    .rst   (i_rst),
    .push  (fifo_push),
    .wdata (i_res_data),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .empty (fifo_empty),
    .full  (fifo_full),
    .head  (fifo_head)
  );

  always_ff @(posedge CLK100MHZ) begin
    gpio_q <= gpio_d;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (i_rst) begin
      prev_q       <= '0;
      state_q      <= S_IDLE;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      start_pend_q <= 1'b0;
      soft_rst_q   <= 1'b0;
      start_q      <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_data_q    <= '0;
    end else begin
      prev_q       <= prev_d;
      state_q      <= state_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      start_pend_q <= start_pend_d;
      soft_rst_q   <= soft_rst_d;
      start_q      <= start_d;
      wr_valid_q   <= wr_valid_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // Status word is assembled purely from registers.
  always_comb begin
    o_gpio_i                          = '0;
    o_gpio_i[ST_BUSY]                 = busy_q;
    o_gpio_i[ST_DONE]                 = done_q;
    o_gpio_i[ST_EMPTY]                = fifo_empty;
    o_gpio_i[ST_FULL]                 = fifo_full;
    o_gpio_i[ST_ERR]                  = err_q;
    o_gpio_i[PAYLOAD_LSB +: NB_RES]   = fifo_head;
  end

  assign o_soft_rst = soft_rst_q;
  assign o_start    = start_q;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_data  = wr_data_q;
  assign o_led      = done_q;

endmodule

// File: tb/tb_gpio_cmd_bridge.sv
// Self-checking bench for gpio_cmd_bridge: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based behavioural model.
module tb_gpio_cmd_bridge;

  localparam int DEPTH = 8;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_gpio_o;
  logic [31:0] o_gpio_i;
  logic        o_soft_rst, o_start, o_wr_valid;
  logic [23:0] o_wr_data;
  logic        i_res_valid;
  logic [12:0] i_res_data;
  logic        o_res_ready;
  logic        i_done;
  logic        o_led;

  gpio_cmd_bridge dut (
    .CLK100MHZ   (clk),
    .i_rst       (i_rst),
    .i_gpio_o    (i_gpio_o),
    .o_gpio_i    (o_gpio_i),
    .o_soft_rst  (o_soft_rst),
    .o_start     (o_start),
    .o_wr_valid  (o_wr_valid),
    .o_wr_data   (o_wr_data),
    .i_res_valid (i_res_valid),
    .i_res_data  (i_res_data),
    .o_res_ready (o_res_ready),
    .i_done      (i_done),
    .o_led       (o_led)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned q[$];
  int          m_st;
  bit          m_done, m_err, m_pend;
  logic [31:0] m_cur = '0, m_prev = '0;
  bit          e_soft, e_start, e_wv;
  logic [23:0] e_wd;
  bit          model_ok = 1'b0;

  function automatic logic [3:0] m_rise();
    return m_cur[3:0] & ~m_prev[3:0];
  endfunction

  function automatic bit m_ready();
    logic [3:0] r;
    r = m_rise();
    if (r[0]) return 1'b0;
    return (q.size() < DEPTH) || (r[2] && q.size() > 0);
  endfunction

  function automatic logic [31:0] m_gpio();
    logic [31:0] w;
    w      = '0;
    w[0]   = (m_st == M_RUN);
    w[1]   = m_done;
    w[2]   = (q.size() == 0);
    w[3]   = (q.size() == DEPTH);
    w[4]   = m_err;
    w[31:8] = (q.size() > 0) ? 24'(q[0]) : 24'h0;
    return w;
  endfunction

  task automatic model_edge();
    logic [3:0] r;
    bit acc, was_pend;
    e_soft = 0; e_start = 0; e_wv = 0;
    if (i_rst) begin
      q.delete();
      m_st = M_IDLE; m_done = 0; m_err = 0; m_pend = 0; e_wd = '0;
      m_prev = '0; m_cur = i_gpio_o; model_ok = 1;
      return;
    end
    r   = m_rise();
    acc = i_res_valid && m_ready();
    if (r[0]) begin
      e_soft = 1; q.delete(); m_err = 0; m_done = 0; m_st = M_IDLE; m_pend = 0;
    end else begin
      if (r[2]) begin
        if (q.size() == 0) m_err = 1;
        else void'(q.pop_front());
      end
      if (acc) q.push_back(int'(i_res_data));
      was_pend = m_pend;
      m_pend   = 0;
      if (was_pend) begin
        e_start = 1; m_st = M_RUN; m_done = 0;
        if (r[3] || r[1]) m_err = 1;
      end else if (m_st == M_RUN) begin
        if (r[3] || r[1]) m_err = 1;
        if (i_done) begin m_st = M_DONE; m_done = 1; end
      end else if (r[3]) begin
        e_wv = 1; e_wd = m_cur[31:8]; m_st = M_LOAD; m_done = 0; m_pend = r[1];
      end else if (r[1]) begin
        e_start = 1; m_st = M_RUN; m_done = 0;
      end
    end
    m_prev = m_cur;
    m_cur  = i_gpio_o;
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  // Every-cycle comparison, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      chk("cmp_gpio",  o_gpio_i, m_gpio());
      chk("cmp_soft",  32'(o_soft_rst), 32'(e_soft));
      chk("cmp_start", 32'(o_start), 32'(e_start));
      chk("cmp_wv",    32'(o_wr_valid), 32'(e_wv));
      chk("cmp_led",   32'(o_led), 32'(m_done));
      chk("cmp_ready", 32'(o_res_ready), 32'(m_ready()));
      if (e_wv) chk("cmp_wdata", 32'(o_wr_data), 32'(e_wd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse(input logic [31:0] w);
    i_gpio_o = w;
    tick();
    i_gpio_o = 32'h0;
    tick();
  endtask

  initial begin
    logic [31:0] rnd;
    logic [3:0]  cmd;
    i_rst = 1'b1; i_gpio_o = 32'h0000_5508; i_res_valid = 1'b0;
    i_res_data = '0; i_done = 1'b0;
    tick(3);
    chk("rst_gpio",  o_gpio_i, 32'h0000_0004);
    chk("rst_pulses", {29'b0, o_soft_rst, o_start, o_wr_valid}, 32'h0);
    chk("rst_wdata", 32'(o_wr_data), 32'h0);
    chk("rst_led",   32'(o_led), 32'h0);
    chk("rst_ready", 32'(o_res_ready), 32'h1);
    chk("model_rst_gpio", m_gpio(), 32'h0000_0004);

    // WRITE held high through reset fires right after release
    i_rst = 1'b0;
    tick();
    chk("held_wv", 32'(o_wr_valid), 32'h1);
    chk("held_wd", 32'(o_wr_data), 32'h0000_0055);
    tick();
    chk("held_no_repeat", 32'(o_wr_valid), 32'h0);
    i_gpio_o = 32'h0;
    tick();

    // WRITE 0x108
    i_gpio_o = 32'h0000_0108;
    tick();
    chk("wr_early", 32'(o_wr_valid), 32'h0);
    tick();
    chk("wr_valid", 32'(o_wr_valid), 32'h1);
    chk("wr_data",  32'(o_wr_data), 32'h0000_0001);
    chk("wr_gpio",  o_gpio_i, 32'h0000_0004);
    i_gpio_o = 32'h0;
    tick();

    // START, results 3/5/7, done
    pulse(32'h2);
    chk("start_pulse", 32'(o_start), 32'h1);
    chk("start_busy", o_gpio_i, 32'h0000_0005);
    i_res_valid = 1'b1; i_res_data = 13'd3; tick();
    chk("run_head3", o_gpio_i, 32'h0000_0301);
    i_res_data = 13'd5; tick();
    i_res_data = 13'd7; tick();
    i_res_valid = 1'b0; i_done = 1'b1; tick(); i_done = 1'b0;
    chk("done_gpio", o_gpio_i, 32'h0000_0302);
    chk("done_led",  32'(o_led), 32'h1);
    chk("model_done_gpio", m_gpio(), 32'h0000_0302);
    pulse(32'h4); chk("rd1", o_gpio_i, 32'h0000_0502);
    pulse(32'h4); chk("rd2", o_gpio_i, 32'h0000_0702);
    pulse(32'h4); chk("rd3", o_gpio_i, 32'h0000_0006);

    // WRITE+START together from DONE: write now, start one cycle later
    i_gpio_o = 32'hABCD_EF0A;
    tick(2);
    chk("ws_wv",    32'(o_wr_valid), 32'h1);
    chk("ws_wd",    32'(o_wr_data), 32'h00AB_CDEF);
    chk("ws_nostart", 32'(o_start), 32'h0);
    chk("ws_led",   32'(o_led), 32'h0);
    tick();
    chk("ws_start", 32'(o_start), 32'h1);
    chk("ws_gpio",  o_gpio_i, 32'h0000_0005);
    i_gpio_o = 32'h0;
    tick();

    // Fill the FIFO, then swap a word through a pop while full
    for (int k = 0; k < 8; k++) begin
      i_res_valid = 1'b1; i_res_data = 13'(100 + k); tick();
    end
    chk("full_gpio",  o_gpio_i, 32'h0000_6409);
    chk("full_ready", 32'(o_res_ready), 32'h0);
    i_res_data = 13'd200; tick();
    chk("held_off", o_gpio_i, 32'h0000_6409);
    i_gpio_o = 32'h4; tick();
    chk("pop_ready", 32'(o_res_ready), 32'h1);
    i_gpio_o = 32'h0; tick();
    i_res_valid = 1'b0;
    chk("swap_gpio", o_gpio_i, 32'h0000_6509);

    // START while running -> error, no pulse
    pulse(32'h2);
    chk("run_start_none", 32'(o_start), 32'h0);
    chk("run_start_err",  o_gpio_i, 32'h0000_6519);

    // Leave 4 words, then SOFT_RST with START
    for (int k = 0; k < 4; k++) pulse(32'h4);
    pulse(32'h3);
    chk("soft_pulse",   32'(o_soft_rst), 32'h1);
    chk("soft_nostart", 32'(o_start), 32'h0);
    chk("soft_gpio",    o_gpio_i, 32'h0000_0004);
    tick();
    chk("soft_after", {30'b0, o_soft_rst, o_start}, 32'h0);

    // READ on empty -> error
    pulse(32'h4);
    chk("empty_rd_err", o_gpio_i, 32'h0000_0014);

    // Hard reset mid-RUN with 4 words buffered
    pulse(32'h2);
    chk("rerun_gpio", o_gpio_i, 32'h0000_0015);
    for (int k = 0; k < 4; k++) begin
      i_res_valid = 1'b1; i_res_data = 13'(11 + k); tick();
    end
    i_res_valid = 1'b0;
    i_rst = 1'b1; tick();
    chk("hrst_gpio",   o_gpio_i, 32'h0000_0004);
    chk("hrst_pulses", {29'b0, o_soft_rst, o_start, o_wr_valid}, 32'h0);
    chk("hrst_wd",     32'(o_wr_data), 32'h0);
    chk("hrst_led",    32'(o_led), 32'h0);
    i_rst = 1'b0; tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rnd = $urandom();
      cmd = i_gpio_o[3:0];
      if ($urandom_range(0, 39) == 0) cmd[0] = ~cmd[0];
      if ($urandom_range(0, 5)  == 0) cmd[1] = ~cmd[1];
      if ($urandom_range(0, 3)  == 0) cmd[2] = ~cmd[2];
      if ($urandom_range(0, 4)  == 0) cmd[3] = ~cmd[3];
      i_gpio_o    = {rnd[31:4], cmd};
      i_res_valid = 1'($urandom_range(0, 1));
      i_res_data  = 13'($urandom_range(0, 8191));
      i_done      = ($urandom_range(0, 9) == 0);
      i_rst       = ($urandom_range(0, 299) == 0);
      tick();
    end
    i_rst = 1'b0; i_res_valid = 1'b0; i_done = 1'b0; i_gpio_o = 32'h0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
